// File: rtl/bit32_out_fifo_if.sv
// Handshake bundle between the 32-bit mux output, the output FIFO and its consumer.
// The slave modport is the FIFO side. The master modport is the side that drives words in and takes them out.
interface bit32_out_fifo_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    count;
  logic             ovf;
  logic             ovf_clr;

  modport slave (
    input  in_data, in_valid, out_ready, ovf_clr,
    output in_ready, out_data, out_valid, count, ovf
  );

  modport master (
    output in_data, in_valid, out_ready, ovf_clr,
    input  in_ready, out_data, out_valid, count, ovf
  );
endinterface

// File: rtl/bit32_out_fifo.sv
// Output queue for the 32-bit 2:1 mux. A pushed word is visible on the edge after it is pushed, with no pass-through.
// in_ready and out_valid come from registers only. A word offered while the queue is full is dropped and sets a sticky ovf flag.
module bit32_out_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  bit32_out_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("bit32_out_fifo: DEPTH must be a power of two, 2 or greater");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             ovf_q;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             drop;

  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);
  assign push  = bus.in_valid && !full;
  assign pop   = bus.out_ready && !empty;
  assign drop  = bus.in_valid && full;

  // Storage has an asynchronous reset, so out_data reads 0 as soon as reset asserts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap when they overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // A drop and a clear on the same edge leave the flag set, so no overflow goes unreported.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.out_data  = mem[rd_ptr];
  assign bus.count     = cnt;
  assign bus.ovf       = ovf_q;
endmodule
